// File: rtl/aib_tg_pkg.sv
// Shared types and word-building helpers for the AIB MAC traffic generator/checker.
package aib_tg_pkg;

  // Galois right-shift taps for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_RST  = 32'h0000_0001;

  // Upper bound on DWIDTH; helpers return this width and callers truncate.
  localparam int MAX_W = 640;

  typedef enum logic [1:0] {G_IDLE, G_RUN, G_DONE} gen_state_t;
  typedef enum logic [1:0] {C_IDLE, C_HUNT, C_LOCK} chk_state_t;

  function automatic logic [31:0] next_lfsr(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

  // Marker positions: bit 40k+39 of every 40-bit lane. The top lane's
  // marker (bit dw-1) is the one forced high by build_word.
  function automatic logic [MAX_W-1:0] marker_mask(input int dw, input bit wm);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_W; i++)
      if (wm && (i < dw) && ((i % 40) == 39)) m[i] = 1'b1;
    return m;
  endfunction

  // LFSR state replicated across the word, then markers stamped in.
  function automatic logic [MAX_W-1:0] build_word(input logic [31:0] s, input int dw,
                                                  input bit wm);
    logic [MAX_W-1:0] w;
    logic [MAX_W-1:0] m;
    w = '0;
    for (int i = 0; i < MAX_W; i++)
      if (i < dw) w[i] = s[i[4:0]];
    m = marker_mask(dw, wm);
    w = w & ~m;
    if (wm) w[dw-1] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/aib_mac_traffic_gen_chk_if.sv
// MAC-side data ports of one AIB channel: transmit toward the MAC, receive from it.
interface aib_mac_traffic_gen_chk_if #(
  parameter int DWIDTH = 80
);
  logic [DWIDTH-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DWIDTH-1:0] rx_data;
  logic              rx_valid;

  // master: the generator/checker; slave: the MAC (or a loopback model)
  modport master (output tx_data, tx_valid, input tx_ready, rx_data, rx_valid);
  modport slave  (input tx_data, tx_valid, output tx_ready, rx_data, rx_valid);
endinterface

// File: rtl/aib_tg_lfsr.sv
// 32-bit Galois LFSR with synchronous load and single-step advance.
module aib_tg_lfsr
  import aib_tg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        adv,
  input  logic [31:0] seed,
  output logic [31:0] state
);

  // Load beats advance so a restart always begins at the new seed.
  always_ff @(posedge clk) begin
    if (rst)       state <= LFSR_RST;
    else if (load) state <= seed;
    else if (adv)  state <= next_lfsr(state);
  end

endmodule

// File: rtl/aib_mac_traffic_gen_chk.sv
// Per-channel LFSR traffic generator and lock-then-check receive checker.
module aib_mac_traffic_gen_chk
  import aib_tg_pkg::*;
#(
  parameter int DWIDTH  = 80,
  parameter int CNT_W   = 16,
  parameter int HUNT_TO = 1024,
  parameter int WM_EN   = 1
) (
  input  logic                   wr_clk,
  input  logic                   wr_rst,
  input  logic                   start,
  input  logic [31:0]            seed,
  input  logic [CNT_W-1:0]       num_pkts,
  aib_mac_traffic_gen_chk_if.master bus,
  output logic [CNT_W-1:0]       rcv_cnt,
  output logic [CNT_W-1:0]       err_cnt,
  output logic                   locked,
  output logic                   timeout,
  output logic                   done
);

  localparam int HUNT_W = $clog2(HUNT_TO + 1);
  localparam bit WM     = (WM_EN != 0);
  localparam logic [DWIDTH-1:0] MASK = DWIDTH'(marker_mask(DWIDTH, WM));

  // ---------------- generator ----------------
  gen_state_t        g_state;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  sent_cnt;
  logic [31:0]       g_lfsr;
  logic              tx_vld_q;
  logic              g_acc;

  // start overrides a coincident handshake: the word is not counted
  assign g_acc = tx_vld_q && bus.tx_ready && !start;

  aib_tg_lfsr u_gen_lfsr (
    .clk   (wr_clk),
    .rst   (wr_rst),
    .load  (start),
    .adv   (g_acc),
    .seed  (seed),
    .state (g_lfsr)
  );

  // tx_data depends only on registered state, so it holds while stalled
  assign bus.tx_valid = tx_vld_q;
  assign bus.tx_data  = tx_vld_q ? DWIDTH'(build_word(g_lfsr, DWIDTH, WM)) : '0;

  // Generator FSM: IDLE -> RUN -> DONE, restartable from any state
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      g_state  <= G_IDLE;
      tx_vld_q <= 1'b0;
      sent_cnt <= '0;
      num_q    <= '0;
    end else if (start) begin
      num_q    <= num_pkts;
      sent_cnt <= '0;
      if (num_pkts == '0) begin
        g_state  <= G_DONE;
        tx_vld_q <= 1'b0;
      end else begin
        g_state  <= G_RUN;
        tx_vld_q <= 1'b1;
      end
    end else begin
      case (g_state)
        G_RUN: if (g_acc) begin
          sent_cnt <= sent_cnt + 1'b1;
          if (sent_cnt + 1'b1 == num_q) begin
            g_state  <= G_DONE;
            tx_vld_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- checker ----------------
  chk_state_t        c_state;
  logic [HUNT_W-1:0] hunt_cnt;
  logic [31:0]       c_lfsr;
  logic [DWIDTH-1:0] c_exp;
  logic [DWIDTH-1:0] c_diff;
  logic              pay_bad;
  logic              mk_bad;
  logic              hunt_hit;
  logic              c_adv;

  assign c_exp    = DWIDTH'(build_word(c_lfsr, DWIDTH, WM));
  assign c_diff   = bus.rx_data ^ c_exp;
  assign pay_bad  = |(c_diff & ~MASK);
  // MASK is all-zero without markers, so this term vanishes then
  assign mk_bad   = |(c_diff & MASK);
  // Lock qualification ignores markers; once locked, markers are checked too
  assign hunt_hit = bus.rx_valid && !pay_bad && (c_state == C_HUNT);
  assign c_adv    = !start && (hunt_hit || (bus.rx_valid && (c_state == C_LOCK)));

  aib_tg_lfsr u_chk_lfsr (
    .clk   (wr_clk),
    .rst   (wr_rst),
    .load  (start),
    .adv   (c_adv),
    .seed  (seed),
    .state (c_lfsr)
  );

  // Checker FSM: IDLE -> HUNT -> LOCK -> IDLE, with hunt timeout
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      c_state  <= C_IDLE;
      hunt_cnt <= '0;
      rcv_cnt  <= '0;
      err_cnt  <= '0;
      locked   <= 1'b0;
      timeout  <= 1'b0;
    end else if (start) begin
      hunt_cnt <= '0;
      rcv_cnt  <= '0;
      err_cnt  <= '0;
      locked   <= 1'b0;
      timeout  <= 1'b0;
      c_state  <= (num_pkts == '0) ? C_IDLE : C_HUNT;
    end else begin
      case (c_state)
        C_HUNT: begin
          if (hunt_hit) begin
            rcv_cnt <= CNT_W'(1);
            if (num_q == CNT_W'(1)) begin
              c_state <= C_IDLE;
              locked  <= 1'b0;
            end else begin
              c_state <= C_LOCK;
              locked  <= 1'b1;
            end
          end else if (hunt_cnt == HUNT_W'(HUNT_TO - 1)) begin
            timeout <= 1'b1;
            c_state <= C_IDLE;
          end else begin
            hunt_cnt <= hunt_cnt + 1'b1;
          end
        end
        C_LOCK: if (bus.rx_valid) begin
          rcv_cnt <= rcv_cnt + 1'b1;
          if ((pay_bad || mk_bad) && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
          if (rcv_cnt + 1'b1 == num_q) begin
            c_state <= C_IDLE;
            locked  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky completion: generator finished and checker saw every word
  always_ff @(posedge wr_clk) begin
    if (wr_rst || start)                              done <= 1'b0;
    else if ((g_state == G_DONE) && (rcv_cnt == num_q)) done <= 1'b1;
  end

endmodule

// File: tb/tb_aib_mac_traffic_gen_chk.sv
// Loopback bench: 3-stage channel model, tx scoreboard, checker status checks.
module tb_aib_mac_traffic_gen_chk;

  localparam int DW = 80;
  localparam int CW = 16;

  logic          wr_clk = 1'b0;
  logic          wr_rst = 1'b1;
  logic          start  = 1'b0;
  logic [31:0]   seed   = 32'h1;
  logic [CW-1:0] num_pkts = '0;
  logic [CW-1:0] rcv_cnt, err_cnt;
  logic          locked, timeout, done;

  aib_mac_traffic_gen_chk_if #(.DWIDTH(DW)) bus();

  aib_mac_traffic_gen_chk #(.DWIDTH(DW), .CNT_W(CW), .HUNT_TO(1024), .WM_EN(1)) u_dut (
    .wr_clk   (wr_clk),
    .wr_rst   (wr_rst),
    .start    (start),
    .seed     (seed),
    .num_pkts (num_pkts),
    .bus      (bus.master),
    .rcv_cnt  (rcv_cnt),
    .err_cnt  (err_cnt),
    .locked   (locked),
    .timeout  (timeout),
    .done     (done)
  );

  always #5 wr_clk = ~wr_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // reference model: x^32+x^22+x^2+x+1, shift right, feed back on bit 0
  function automatic logic [31:0] m_next(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  function automatic logic [DW-1:0] m_build(input logic [31:0] s);
    logic [95:0]   rep;
    logic [DW-1:0] w;
    rep   = {s, s, s};
    w     = rep[DW-1:0];
    w[79] = 1'b1;
    w[39] = 1'b0;
    return w;
  endfunction

  logic [DW-1:0] sb_q[$];

  // channel model knobs
  logic line_en = 1'b1;
  int   flip_a  = -1;
  int   flip_b  = -1;
  int   mk_idx  = -1;
  bit   bp_en   = 1'b0;
  logic tx_rdy  = 1'b1;
  int   phase   = 0;

  function automatic logic [DW-1:0] corrupt(input logic [DW-1:0] d, input int n);
    logic [DW-1:0] w;
    w = d;
    if (n == flip_a || n == flip_b) w[5] = ~w[5];
    if (n == mk_idx) w[79] = 1'b0;
    return w;
  endfunction

  // 3-cycle loopback line from tx handshake to rx
  logic [DW:0] pipe0 = '0, pipe1 = '0, pipe2 = '0;
  int line_n = 0;
  always @(posedge wr_clk) begin
    if (wr_rst) begin
      pipe0 <= '0; pipe1 <= '0; pipe2 <= '0; line_n <= 0;
    end else begin
      pipe1 <= pipe0;
      pipe2 <= pipe1;
      if (bus.tx_valid && bus.tx_ready) begin
        pipe0  <= {1'b1, corrupt(bus.tx_data, line_n)};
        line_n <= start ? 0 : line_n + 1;
      end else begin
        pipe0  <= '0;
        if (start) line_n <= 0;
      end
    end
  end
  assign bus.rx_valid = pipe2[DW] & line_en;
  assign bus.rx_data  = pipe2[DW-1:0];
  assign bus.tx_ready = tx_rdy;

  // tx_ready pattern: ready, stall, ready, ... when backpressure is on
  always begin
    @(posedge wr_clk);
    #1;
    tx_rdy = bp_en ? (phase != 1) : 1'b1;
    phase  = (phase + 1) % 3;
  end

  // tx monitor: pop expected words on handshake, check hold during stall
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  always @(negedge wr_clk) begin
    if (wr_rst || start) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && bus.tx_valid) chk("tx_hold", bus.tx_data, prev_data);
      if (bus.tx_valid && bus.tx_ready) begin
        chk("tx_avail", DW'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) chk("tx_data", bus.tx_data, sb_q.pop_front());
      end
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_data  = bus.tx_data;
    end
  end

  task automatic do_start(input logic [31:0] s, input logic [CW-1:0] n);
    logic [31:0] st;
    @(posedge wr_clk);
    #1;
    start    = 1'b1;
    seed     = s;
    num_pkts = n;
    sb_q.delete();
    st = s;
    for (int i = 0; i < int'(n); i++) begin
      sb_q.push_back(m_build(st));
      st = m_next(st);
    end
    @(posedge wr_clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done && k < 3000) begin
      @(posedge wr_clk);
      #1;
      k++;
    end
    chk({tag, "_done"}, DW'(done), 1);
  endtask

  task automatic end_checks(input string tag, input int exp_err);
    chk({tag, "_rcv"},    DW'(rcv_cnt), 100);
    chk({tag, "_err"},    DW'(err_cnt), DW'(exp_err));
    chk({tag, "_locked"}, DW'(locked), 0);
    chk({tag, "_tmo"},    DW'(timeout), 0);
    chk({tag, "_sbleft"}, DW'(sb_q.size()), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge wr_clk);
    #1;
    chk("rst_txv",  DW'(bus.tx_valid), 0);
    chk("rst_txd",  bus.tx_data, '0);
    chk("rst_rcv",  DW'(rcv_cnt), 0);
    chk("rst_err",  DW'(err_cnt), 0);
    chk("rst_lock", DW'(locked), 0);
    chk("rst_tmo",  DW'(timeout), 0);
    chk("rst_done", DW'(done), 0);
    wr_rst = 1'b0;

    // loopback with lock latency
    do_start(32'hACE1, 100);
    chk("lb_txv_lat", DW'(bus.tx_valid), 1);
    n = 0;
    while (!locked && n < 20) begin
      @(posedge wr_clk);
      #1;
      n++;
    end
    chk("lb_lock_lat", DW'(n), 4);
    wait_done("lb");
    end_checks("lb", 0);

    // backpressure
    bp_en = 1'b1;
    do_start(32'h5A5A_0F0F, 100);
    wait_done("bp");
    end_checks("bp", 0);
    bp_en = 1'b0;

    // payload bit errors on words 10 and 11
    flip_a = 10; flip_b = 11;
    do_start(32'hC0DE_0001, 100);
    wait_done("inj");
    end_checks("inj", 2);
    flip_a = -1; flip_b = -1;

    // marker bit 79 cleared on one word
    mk_idx = 20;
    do_start(32'h0BAD_F00D, 100);
    wait_done("mk");
    end_checks("mk", 1);
    mk_idx = -1;

    // no data: hunt timeout exactly at 1024 hunt cycles
    line_en = 1'b0;
    do_start(32'hACE1, 100);
    repeat (1023) @(posedge wr_clk);
    #1;
    chk("nd_tmo_pre", DW'(timeout), 0);
    @(posedge wr_clk);
    #1;
    chk("nd_tmo", DW'(timeout), 1);
    repeat (76) @(posedge wr_clk);
    #1;
    chk("nd_locked", DW'(locked), 0);
    chk("nd_done",   DW'(done), 0);
    chk("nd_rcv",    DW'(rcv_cnt), 0);
    chk("nd_tmo_st", DW'(timeout), 1);
    line_en = 1'b1;

    // restart mid-LOCK
    do_start(32'hBEEF, 100);
    n = 0;
    while (!locked && n < 50) begin
      @(posedge wr_clk);
      #1;
      n++;
    end
    chk("rs_lock1", DW'(locked), 1);
    repeat (20) @(posedge wr_clk);
    do_start(32'h1234, 100);
    chk("rs_rcv_clr",  DW'(rcv_cnt), 0);
    chk("rs_err_clr",  DW'(err_cnt), 0);
    chk("rs_lock_clr", DW'(locked), 0);
    wait_done("rs");
    end_checks("rs", 0);

    // zero packets: straight to done, nothing sent
    do_start(32'hACE1, 0);
    chk("z_txv",      DW'(bus.tx_valid), 0);
    chk("z_done_clr", DW'(done), 0);
    @(posedge wr_clk);
    #1;
    chk("z_done", DW'(done), 1);
    chk("z_rcv",  DW'(rcv_cnt), 0);

    // reset mid-run
    do_start(32'hACE1, 100);
    repeat (20) @(posedge wr_clk);
    #1;
    chk("mr_locked_pre", DW'(locked), 1);
    wr_rst = 1'b1;
    @(posedge wr_clk);
    #1;
    chk("mr_txv",  DW'(bus.tx_valid), 0);
    chk("mr_txd",  bus.tx_data, '0);
    chk("mr_rcv",  DW'(rcv_cnt), 0);
    chk("mr_lock", DW'(locked), 0);
    chk("mr_done", DW'(done), 0);
    sb_q.delete();
    wr_rst = 1'b0;
    repeat (2) @(posedge wr_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
